debug_uart_tx: RTL and testbench
================================

# debug_uart_tx

Debug snapshot transmitter. It captures the CPU's seven 8-bit debug ports on request and serialises them off-chip as one framed UART byte stream, so that a host or a bench-side UART receiver can log them. It is the on-chip sending end of the debug-port readout. It sits next to `cpu` and takes `debug_port1`..`debug_port7` directly.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range is 2 or more.
- `AUTO`, default 0: when 1, a new frame starts automatically whenever the block is idle and `trigger` is ignored.
- `clk` input, 1 bit: the only clock; all logic is on the rising edge.
- `nreset` input, 1 bit: synchronous reset, active-high (`nreset`=1 resets on the next rising edge of `clk`).
- `trigger` input, 1 bit: single-cycle request to capture the ports and send a frame.
- `debug_port1`..`debug_port7` input, 8 bits each: values to capture.
- `tx` output, 1 bit: UART line, 8N1, LSB first, idles high.
- `busy` output, 1 bit: high while a frame is in flight.
- `frame_done` output, 1 bit: one-cycle pulse when a frame completes.
- `overrun` output, 1 bit: sticky flag, set when `trigger` is asserted while `busy`=1.

## Operation
- **Frame format:** 9 bytes sent back to back, with no idle gap between bytes.
  - Byte 0: sync byte 0xA5.
  - Bytes 1..7: snapshot of `debug_port1`..`debug_port7`, in that order.
  - Byte 8: checksum, the XOR of snapshot bytes 1..7 (the sync byte is excluded).
- **Byte encoding:** start bit (0), then data bits 0..7, then stop bit (1). Each byte is 10 bits; each bit is held exactly `CLKS_PER_BIT` cycles.
- **Snapshot:** all seven ports are registered in the cycle `trigger` is accepted. Port changes after that cycle do not affect the frame in flight. The checksum is computed from the snapshot, not from the live ports.
- **FSM states:**
  - IDLE: `tx`=1, `busy`=0. Go to START on an accepted trigger.
  - START: drive start bit. Go to DATA after `CLKS_PER_BIT` cycles.
  - DATA: shift out 8 bits. Go to STOP after the 8th bit.
  - STOP: drive stop bit. If byte index < 8, increment it and go to START. Otherwise go to DONE.
  - DONE: one cycle; `frame_done`=1, `busy`=0, `tx`=1. Go to IDLE.
- **Counters:** a bit-cycle counter of width clog2(`CLKS_PER_BIT`), a bit index 0..7, and a byte index 0..8. The byte index does not wrap within a frame.
- **Accepting a trigger:** accepted in IDLE or DONE (`trigger`, or `AUTO`=1).
  - A trigger in the same cycle as `frame_done` is accepted; the next frame's start bit follows with no idle cycle.
  - Trigger while `busy`=1: ignored, and `overrun` is set. The frame in flight is unaffected.
- **Reset:** the reset values below apply whenever `nreset`=1 is sampled, including mid-frame. The partial frame is abandoned and no `frame_done` pulse is produced for it.

## Timing
- **Reset values:** `tx`=1, `busy`=0, `frame_done`=0, `overrun`=0. FSM in IDLE, all counters 0, snapshot registers 0.
- **Trigger to line:** trigger sampled at edge T. Then `busy`=1 and `tx`=0 (start bit of the sync byte) from T+1.
- **Bit boundaries:** bit k of the frame (k=0..89) occupies cycles T+1+k·CPB through T+(k+1)·CPB.
- **End of frame:** `busy`=1 for exactly 90·CPB cycles. `frame_done`=1 at cycle T+1+90·CPB. The earliest next start bit is at T+2+90·CPB.
- **Repetition:** with `AUTO`=1, frames repeat with a period of 90·CPB+1 cycles.
- **`overrun`:** visible one cycle after the offending trigger.

## Test plan
- **Reset then idle:** hold `nreset`=1 for 2 cycles, release, wait 50 cycles with no trigger. Required: `tx`=1, `busy`=0, `frame_done`=0, `overrun`=0 throughout.
- **Basic frame:** CPB=4; ports = 0xFF,00,00,00,00,00,0x0F; pulse `trigger`. A bench UART receiver must decode the bytes A5 FF 00 00 00 00 00 0F F0. Also required: `busy` high for exactly 360 cycles, and `frame_done` one cycle at T+361.
- **Snapshot stability:** as the basic-frame test, but change all ports to 0x55 one cycle after the trigger. The decoded frame must be unchanged (checksum still F0).
- **Overrun:** pulse `trigger` again 100 cycles into a frame. Required: `overrun`=1 from the next cycle, the frame bytes unaffected, and no second frame afterwards.
- **Back-to-back frames:** assert `trigger` in the same cycle as `frame_done`. Required: `tx`=0 in the very next cycle. Separately, with `AUTO`=1, verify three consecutive frames with a period of 90·CPB+1.
- **Reset mid-frame:** assert `nreset` during byte 4. Required next cycle: `tx`=1, `busy`=0, and no `frame_done`. A subsequent trigger must produce a clean, complete frame starting with A5.

Source files
------------

// File: rtl/debug_uart_tx.sv
// Debug snapshot transmitter: captures seven debug ports and sends them as a
// 9-byte 8N1 UART frame (sync 0xA5, ports 1..7, XOR checksum of the ports).
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit AUTO         = 1'b0
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       trigger,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic [2:0] dbg_state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      byte_q, byte_d;
    logic [6:0][7:0] snap_q, snap_d;
    logic            overrun_q, overrun_d;

    logic            accept;
    logic            in_frame;
    logic            bit_end;
    logic [7:0]      checksum;
    logic [7:0]      cur_byte;
    logic [2:0]      snap_idx;

    always_comb begin
        checksum = 8'h00;
        for (int i = 0; i < 7; i++) begin
            checksum = checksum ^ snap_q[i];
        end
    end

    // Byte 0 is the sync byte, 1..7 the snapshot, 8 the checksum.
    always_comb begin
        snap_idx = 3'(byte_q - 4'd1);
        cur_byte = SYNC_BYTE;
        if (byte_q == 4'd8) begin
            cur_byte = checksum;
        end else if (byte_q != 4'd0) begin
            cur_byte = snap_q[snap_idx];
        end
    end

    assign in_frame = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && (AUTO || trigger);
    assign bit_end  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;

        if (!AUTO && trigger && in_frame) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    byte_d  = 4'd0;
                    snap_d  = {debug_port7, debug_port6, debug_port5, debug_port4,
                               debug_port3, debug_port2, debug_port1};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // The byte index holds at 8 through DONE; a new frame reloads it.
                    if (byte_q == 4'd8) begin
                        state_d = S_DONE;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = S_START;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 4'd0;
            snap_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = cur_byte[bit_q];
            default: tx = 1'b1;
        endcase
    end

    assign busy       = in_frame;
    assign frame_done = (state_q == S_DONE);
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: vector table of port snapshots, a cycle-exact UART
// receiver checking bytes against an expected queue, plus corner-case sequences.
module tb_debug_uart_tx;

    localparam int CPB = 4;

    logic            clk = 1'b0;
    logic            nreset = 1'b1;
    logic            nreset_a = 1'b1;
    logic            trigger = 1'b0;
    logic [6:0][7:0] ports = '0;
    logic            tx, busy, frame_done, overrun;
    logic [2:0]      dbg_state;
    logic            tx_a, busy_a, frame_done_a, overrun_a;
    logic [2:0]      dbg_state_a;

    int tests_run = 0;
    int failures  = 0;
    int cyc       = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [6:0][7:0] p;
        logic [7:0]      chk;
    } vec_t;
    vec_t vecs[5];

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .AUTO(1'b0)) dut (
        .clk(clk), .nreset(nreset), .trigger(trigger),
        .debug_port1(ports[0]), .debug_port2(ports[1]), .debug_port3(ports[2]),
        .debug_port4(ports[3]), .debug_port5(ports[4]), .debug_port6(ports[5]),
        .debug_port7(ports[6]),
        .tx(tx), .busy(busy), .frame_done(frame_done), .overrun(overrun),
        .dbg_state(dbg_state)
    );

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .AUTO(1'b1)) dut_a (
        .clk(clk), .nreset(nreset_a), .trigger(trigger),
        .debug_port1(ports[0]), .debug_port2(ports[1]), .debug_port3(ports[2]),
        .debug_port4(ports[3]), .debug_port5(ports[4]), .debug_port6(ports[5]),
        .debug_port7(ports[6]),
        .tx(tx_a), .busy(busy_a), .frame_done(frame_done_a), .overrun(overrun_a),
        .dbg_state(dbg_state_a)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] a, b, c, d, e, f, g, input logic [7:0] chk);
        vec_t v;
        v.p   = {g, f, e, d, c, b, a};
        v.chk = chk;
        return v;
    endfunction

    task automatic push_frame(input int v);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 7; i++) exp_q.push_back(vecs[v].p[i]);
        exp_q.push_back(vecs[v].chk);
    endtask

    task automatic start_frame(input int v, input bit change_after);
        @(posedge clk); #1;
        ports = vecs[v].p;
        push_frame(v);
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
        if (change_after) ports = {7{8'h55}};
    endtask

    // Follows one frame from the cycle after its accepting edge (n=1).
    task automatic watch_frame(input int ov_at, input bit chain, input int cvec,
                               output int done_at, output int busy_cnt);
        done_at  = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("start_tx_low", tx, 1'b0);
                check("start_busy", busy, 1'b1);
            end
            if (busy) busy_cnt++;
            if (ov_at > 0 && n == ov_at) begin
                check("overrun_before", overrun, 1'b0);
                trigger = 1'b1;
            end
            if (ov_at > 0 && n == ov_at + 1) begin
                trigger = 1'b0;
                check("overrun_set", overrun, 1'b1);
            end
            if (frame_done) begin
                done_at = n;
                if (chain) begin
                    ports = vecs[cvec].p;
                    push_frame(cvec);
                    trigger = 1'b1;
                end
                break;
            end
        end
    endtask

    task automatic frame_end_checks(input int done_at, input int busy_cnt);
        check("busy_cycles", busy_cnt, 90 * CPB);
        check("frame_done_at", done_at, 90 * CPB + 1);
    endtask

    task automatic idle_after_frame();
        @(negedge clk);
        check("done_one_cycle", frame_done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_tx", tx, 1'b1);
        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Cycle-exact UART receiver: samples each bit mid-way through its CPB cycles.
    int         rx_t = 0;
    bit         rx_active = 1'b0;
    logic [7:0] rx_byte = '0;
    logic [2:0] rx_bidx;
    logic [7:0] rx_exp;
    always @(negedge clk) begin
        if (nreset) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == CPB / 2) begin
                check("rx_start_bit", tx, 1'b0);
            end else if (rx_t < 9 * CPB && (rx_t % CPB) == CPB / 2) begin
                rx_bidx = 3'(rx_t / CPB - 1);
                rx_byte[rx_bidx] = tx;
            end else if (rx_t == 9 * CPB + CPB / 2) begin
                check("rx_stop_bit", tx, 1'b1);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("FAIL rx_unexpected_byte: actual %0h required none", rx_byte);
                end else begin
                    rx_exp = exp_q.pop_front();
                    check("rx_byte", rx_byte, rx_exp);
                end
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        int done_at, busy_cnt, bad, found;
        int d[4];

        vecs[0] = mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hF0);
        vecs[1] = mk(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h7F);
        vecs[2] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[3] = mk(8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55);
        vecs[4] = mk(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_state", dbg_state, 3'd0);
        nreset = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0) bad++;
        end
        check("idle_hold_bad_cycles", bad, 0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            start_frame(v, 1'b0);
            watch_frame(0, 1'b0, 0, done_at, busy_cnt);
            frame_end_checks(done_at, busy_cnt);
            idle_after_frame();
        end

        // Snapshot stability: ports change right after the trigger
        start_frame(0, 1'b1);
        watch_frame(0, 1'b0, 0, done_at, busy_cnt);
        frame_end_checks(done_at, busy_cnt);
        idle_after_frame();

        // Overrun: second trigger 100 cycles into the frame
        start_frame(1, 1'b0);
        watch_frame(100, 1'b0, 0, done_at, busy_cnt);
        frame_end_checks(done_at, busy_cnt);
        idle_after_frame();
        bad = 0;
        repeat (400) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        check("no_second_frame", bad, 0);
        check("overrun_sticky", overrun, 1'b1);
        @(posedge clk); #1 nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1 nreset = 1'b0;
        @(negedge clk);
        check("overrun_cleared", overrun, 1'b0);

        // Back-to-back: trigger in the frame_done cycle
        start_frame(2, 1'b0);
        watch_frame(0, 1'b1, 3, done_at, busy_cnt);
        frame_end_checks(done_at, busy_cnt);
        @(posedge clk); #1 trigger = 1'b0;
        watch_frame(0, 1'b0, 0, done_at, busy_cnt);
        frame_end_checks(done_at, busy_cnt);
        idle_after_frame();

        // Reset during byte 4 (byte 4 starts at n = 1 + 40*CPB)
        start_frame(4, 1'b0);
        for (int n = 1; n <= 1 + 40 * CPB + 9; n++) @(negedge clk);
        check("midrst_busy_before", busy, 1'b1);
        nreset = 1'b1;
        @(negedge clk);
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", frame_done, 1'b0);
        @(negedge clk);
        nreset = 1'b0;
        exp_q.delete();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("midrst_no_done", bad, 0);
        start_frame(3, 1'b0);
        watch_frame(0, 1'b0, 0, done_at, busy_cnt);
        frame_end_checks(done_at, busy_cnt);
        idle_after_frame();

        // AUTO instance: frames repeat every 90*CPB+1 cycles
        @(posedge clk); #1 nreset_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int w = 0; w < 1000; w++) begin
                @(negedge clk);
                if (frame_done_a) begin
                    found = 1;
                    break;
                end
            end
            d[k] = cyc;
            check("auto_done_seen", found, 1);
            @(negedge clk);
            check("auto_restart_tx", tx_a, 1'b0);
            check("auto_restart_busy", busy_a, 1'b1);
        end
        for (int k = 0; k < 3; k++) check("auto_period", d[k+1] - d[k], 90 * CPB + 1);
        @(posedge clk); #1 nreset_a = 1'b1;

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
